// File: rtl/alu16_seq.sv
// Runs 16-bit ALU requests through the shared 8-bit ALU in two chained byte passes.
// Optional single-byte requests are enabled with the ALU16_SEQ_BYTE_EN macro.
module alu16_seq #(
    parameter logic LOGIC_CARRY_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_c,
`ifdef ALU16_SEQ_BYTE_EN
    input  logic        req_byte,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_z,
    output logic        rsp_n,
    output logic        rsp_c,
    output logic [4:0]  alu_inst,
    output logic [15:0] alu_op0,
    output logic [15:0] alu_op1,
    output logic        alu_c_in,
    input  logic [15:0] alu_result,
    input  logic        alu_c
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    // ALU encodings: ADD=0 ADC=1 SUB=2 SBC=3 AND=4 OR=5 XOR=6 SRL=7 SLL=8 PASS=9 PASSW=10
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_ADC  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SBC  = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_PASS = 5'd9;

    typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        c_q, c_d;
    logic [7:0]  first_q, first_d;
    logic        carry_q, carry_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_result_q, rsp_result_d;
    logic        rsp_z_q, rsp_z_d;
    logic        rsp_n_q, rsp_n_d;
    logic        rsp_c_q, rsp_c_d;
    logic        single_pass;

    logic        is_srl;
    logic        is_logic;
    logic        hi_first;
    logic        in_p1;
    logic        use_hi;
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic        pass_c;
    logic [7:0]  second_byte;
    logic [15:0] result16;
    logic        unused_alu_hi;

    assign unused_alu_hi = ^alu_result[15:8];

`ifdef ALU16_SEQ_BYTE_EN
    logic byte_q, byte_d;
    assign single_pass = byte_q;
`else
    assign single_pass = 1'b0;
`endif

    // SRL walks high byte first so its P1 carry-out (a[8]) can be OR-ed into the low byte.
    always_comb begin
        is_srl   = (op_q == OP_SRL);
        is_logic = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
        hi_first = is_srl && !single_pass;
        in_p1    = (state_q == P1);
        use_hi   = in_p1 ? hi_first : !hi_first;
        a_byte   = use_hi ? a_q[15:8] : a_q[7:0];
        b_byte   = use_hi ? b_q[15:8] : b_q[7:0];
        pass_c   = is_srl ? a_q[0] : (is_logic ? (LOGIC_CARRY_CLEAR ? 1'b0 : c_q) : alu_c);

        alu_inst = ALU_PASS;
        alu_op0  = 16'h0000;
        alu_op1  = 16'h0000;
        alu_c_in = 1'b0;
        if (state_q == P1 || state_q == P2) begin
            alu_op0 = {8'h00, a_byte};
            alu_op1 = is_srl ? 16'h0000 : {8'h00, b_byte};
            case (op_q)
                OP_ADD: begin
                    alu_inst = in_p1 ? ALU_ADD : ALU_ADC;
                    alu_c_in = in_p1 ? 1'b0 : carry_q;
                end
                OP_ADC: begin
                    alu_inst = ALU_ADC;
                    alu_c_in = in_p1 ? c_q : carry_q;
                end
                OP_SUB: begin
                    alu_inst = in_p1 ? ALU_SUB : ALU_SBC;
                    alu_c_in = in_p1 ? 1'b0 : carry_q;
                end
                OP_SBC: begin
                    alu_inst = ALU_SBC;
                    alu_c_in = in_p1 ? c_q : carry_q;
                end
                OP_AND:  alu_inst = ALU_AND;
                OP_OR:   alu_inst = ALU_OR;
                OP_XOR:  alu_inst = ALU_XOR;
                default: alu_inst = ALU_SRL;
            endcase
        end

        second_byte = alu_result[7:0] | {is_srl & a_q[8], 7'b0000000};
        result16    = hi_first ? {first_q, second_byte} : {second_byte, first_q};
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        first_d      = first_q;
        carry_d      = carry_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_z_d      = rsp_z_q;
        rsp_n_d      = rsp_n_q;
        rsp_c_d      = rsp_c_q;
`ifdef ALU16_SEQ_BYTE_EN
        byte_d       = byte_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    c_d     = req_c;
`ifdef ALU16_SEQ_BYTE_EN
                    byte_d  = req_byte;
`endif
                    state_d = P1;
                end
            end
            P1: begin
                first_d = alu_result[7:0];
                carry_d = alu_c;
                if (single_pass) begin
                    rsp_result_d = {8'h00, alu_result[7:0]};
                    rsp_z_d      = (alu_result[7:0] == 8'h00);
                    rsp_n_d      = alu_result[7];
                    rsp_c_d      = pass_c;
                    rsp_valid_d  = 1'b1;
                    state_d      = DONE;
                end else begin
                    state_d      = P2;
                end
            end
            P2: begin
                rsp_result_d = result16;
                rsp_z_d      = (result16 == 16'h0000);
                rsp_n_d      = result16[15];
                rsp_c_d      = pass_c;
                rsp_valid_d  = 1'b1;
                state_d      = DONE;
            end
            default: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // Reset drops any in-flight request; ready stays low until the first edge after release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= 3'd0;
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            c_q          <= 1'b0;
            first_q      <= 8'h00;
            carry_q      <= 1'b0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 16'h0000;
            rsp_z_q      <= 1'b0;
            rsp_n_q      <= 1'b0;
            rsp_c_q      <= 1'b0;
`ifdef ALU16_SEQ_BYTE_EN
            byte_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            first_q      <= first_d;
            carry_q      <= carry_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_z_q      <= rsp_z_d;
            rsp_n_q      <= rsp_n_d;
            rsp_c_q      <= rsp_c_d;
`ifdef ALU16_SEQ_BYTE_EN
            byte_q       <= byte_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_n      = rsp_n_q;
    assign rsp_c      = rsp_c_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Testbench for alu16_seq: models the external 8-bit ALU and scoreboards 16-bit results.
// Byte-mode steps are compiled in only when ALU16_SEQ_BYTE_EN is defined.
module tb_alu16_seq;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_c;
`ifdef ALU16_SEQ_BYTE_EN
    logic        req_byte;
`endif
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_z;
    logic        rsp_n;
    logic        rsp_c;
    logic [4:0]  alu_inst;
    logic [15:0] alu_op0;
    logic [15:0] alu_op1;
    logic        alu_c_in;
    logic [15:0] alu_result;
    logic        alu_c;

    typedef struct packed {
        logic [15:0] r;
        logic        z;
        logic        n;
        logic        c;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [4:0]  p2_inst;
    logic        p2_cin;
    logic [15:0] p1_op0;

    always #5 clk = ~clk;

    alu16_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
`ifdef ALU16_SEQ_BYTE_EN
        .req_byte   (req_byte),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_z      (rsp_z),
        .rsp_n      (rsp_n),
        .rsp_c      (rsp_c),
        .alu_inst   (alu_inst),
        .alu_op0    (alu_op0),
        .alu_op1    (alu_op1),
        .alu_c_in   (alu_c_in),
        .alu_result (alu_result),
        .alu_c      (alu_c)
    );

    // External 8-bit ALU: carry is carry-out for add, borrow-not for subtract, shifted-out bit for SRL.
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'h000;
        case (alu_inst)
            5'd0: alu_t = {1'b0, alu_op0[7:0]} + {1'b0, alu_op1[7:0]};
            5'd1: alu_t = {1'b0, alu_op0[7:0]} + {1'b0, alu_op1[7:0]} + {8'h00, alu_c_in};
            5'd2: alu_t = {1'b0, alu_op0[7:0]} + {1'b0, ~alu_op1[7:0]} + 9'd1;
            5'd3: alu_t = {1'b0, alu_op0[7:0]} + {1'b0, ~alu_op1[7:0]} + {8'h00, alu_c_in};
            5'd4: alu_t = {1'b0, alu_op0[7:0] & alu_op1[7:0]};
            5'd5: alu_t = {1'b0, alu_op0[7:0] | alu_op1[7:0]};
            5'd6: alu_t = {1'b0, alu_op0[7:0] ^ alu_op1[7:0]};
            5'd7: alu_t = {alu_op0[0], 1'b0, alu_op0[7:1]};
            default: alu_t = {1'b0, alu_op0[7:0]};
        endcase
        alu_result = {8'h00, alu_t[7:0]};
        alu_c      = alu_t[8];
    end

    // Whole-word reference; logic ops clear carry (default LOGIC_CARRY_CLEAR=1).
    function automatic exp_t refModel(input logic [2:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic c, input logic bytem);
        logic [16:0] s;
        logic [15:0] bx;
        logic [15:0] m;
        logic        cin;
        exp_t        e;
        bx  = (op == OP_SUB || op == OP_SBC) ? ~b : b;
        cin = (op == OP_ADC || op == OP_SBC) ? c : (op == OP_SUB);
        m   = bytem ? 16'h00FF : 16'hFFFF;
        if (bytem) begin
            s   = {8'h00, {1'b0, a[7:0]} + {1'b0, bx[7:0]} + {8'h00, cin}};
            e.r = {8'h00, s[7:0]};
            e.c = s[8];
        end else begin
            s   = {1'b0, a} + {1'b0, bx} + {16'h0000, cin};
            e.r = s[15:0];
            e.c = s[16];
        end
        case (op)
            OP_AND: begin e.r = a & b & m; e.c = 1'b0; end
            OP_OR:  begin e.r = (a | b) & m; e.c = 1'b0; end
            OP_XOR: begin e.r = (a ^ b) & m; e.c = 1'b0; end
            OP_SRL: begin
                e.r = bytem ? {9'h000, a[7:1]} : {1'b0, a[15:1]};
                e.c = a[0];
            end
            default: ;
        endcase
        e.z = (e.r == 16'h0000);
        e.n = bytem ? e.r[7] : e.r[15];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic bytem);
        @(negedge clk);
        chk("req_ready_before_issue", {15'h0, req_ready}, 16'h0001);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_c     = c;
`ifdef ALU16_SEQ_BYTE_EN
        req_byte  = bytem;
`endif
        req_valid = 1'b1;
        sb_q.push_back(refModel(op, a, b, c, bytem));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; lat = edges after accept before rsp_valid is visible.
    task automatic checkOutput(input string tag, input int lat, input int hold);
        int   n;
        exp_t e;
        n      = 0;
        p1_op0 = alu_op0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                p2_inst = alu_inst;
                p2_cin  = alu_c_in;
            end
        end
        chk({tag, "_latency"}, n[15:0], lat[15:0]);
        chk({tag, "_sb_nonempty"}, {15'h0, (sb_q.size() != 0)}, 16'h0001);
        if (rsp_valid !== 1'b1 || sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, "_result"}, rsp_result, e.r);
        chk({tag, "_z"}, {15'h0, rsp_z}, {15'h0, e.z});
        chk({tag, "_n"}, {15'h0, rsp_n}, {15'h0, e.n});
        chk({tag, "_c"}, {15'h0, rsp_c}, {15'h0, e.c});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, {15'h0, rsp_valid}, 16'h0001);
            chk({tag, "_hold_result"}, rsp_result, e.r);
            chk({tag, "_hold_req_ready"}, {15'h0, req_ready}, 16'h0000);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_released_valid"}, {15'h0, rsp_valid}, 16'h0000);
        chk({tag, "_released_ready"}, {15'h0, req_ready}, 16'h0001);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        req_c     = 1'b0;
`ifdef ALU16_SEQ_BYTE_EN
        req_byte  = 1'b0;
`endif
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", {15'h0, req_ready}, 16'h0000);
        chk("reset_rsp_valid", {15'h0, rsp_valid}, 16'h0000);
        chk("reset_rsp_result", rsp_result, 16'h0000);
        chk("reset_flags", {13'h0, rsp_z, rsp_n, rsp_c}, 16'h0000);
        chk("reset_alu_inst", {11'h0, alu_inst}, 16'h0009);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_req_ready", {15'h0, req_ready}, 16'h0001);

        applyStimulus(OP_ADD, 16'h12FF, 16'h0001, 1'b0, 1'b0);
        checkOutput("add_carry_chain", 2, 0);
        chk("add_p1_op0", p1_op0, 16'h00FF);
        chk("add_p2_inst", {11'h0, p2_inst}, 16'h0001);
        chk("add_p2_c_in", {15'h0, p2_cin}, 16'h0001);

        applyStimulus(OP_SUB, 16'h0000, 16'h0001, 1'b0, 1'b0);
        checkOutput("sub_borrow", 2, 0);
        applyStimulus(OP_SBC, 16'h0005, 16'h0005, 1'b1, 1'b0);
        checkOutput("sbc_zero", 2, 0);
        applyStimulus(OP_SRL, 16'h0301, 16'h0000, 1'b0, 1'b0);
        checkOutput("srl_0301", 2, 0);
        applyStimulus(OP_SRL, 16'h0100, 16'hFFFF, 1'b1, 1'b0);
        checkOutput("srl_cross_byte", 2, 0);
        applyStimulus(OP_XOR, 16'hA5A5, 16'hA5A5, 1'b1, 1'b0);
        checkOutput("xor_zero", 2, 0);
        applyStimulus(OP_ADC, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        checkOutput("adc_backpressure", 2, 10);
        applyStimulus(OP_AND, 16'hF0F0, 16'h3C3C, 1'b1, 1'b0);
        checkOutput("and_back_to_back", 2, 0);
        applyStimulus(OP_OR, 16'h8001, 16'h0100, 1'b0, 1'b0);
        checkOutput("or_negative", 2, 0);
        applyStimulus(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("add_wrap", 2, 0);

        // Reset pulsed while the request is in its second pass.
        @(negedge clk);
        req_op    = OP_ADD;
        req_a     = 16'h1234;
        req_b     = 16'h1111;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_rsp_valid", {15'h0, rsp_valid}, 16'h0000);
        chk("midreset_req_ready", {15'h0, req_ready}, 16'h0000);
        chk("midreset_alu_inst", {11'h0, alu_inst}, 16'h0009);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_midreset_req_ready", {15'h0, req_ready}, 16'h0001);
        repeat (4) @(posedge clk);
        #1;
        chk("dropped_no_response", {15'h0, rsp_valid}, 16'h0000);
        applyStimulus(OP_SUB, 16'h8000, 16'h0001, 1'b0, 1'b0);
        checkOutput("sub_after_reset", 2, 0);

        for (int k = 0; k < 8; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom_range(0, 1));
            applyStimulus(rop, ra, rb, rc, 1'b0);
            checkOutput("random_op", 2, k % 3);
        end

`ifdef ALU16_SEQ_BYTE_EN
        applyStimulus(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 1'b1);
        checkOutput("byte_add", 1, 0);
        applyStimulus(OP_SRL, 16'h0301, 16'h0000, 1'b0, 1'b1);
        checkOutput("byte_srl", 1, 0);
        applyStimulus(OP_SUB, 16'h1200, 16'h3401, 1'b0, 1'b1);
        checkOutput("byte_sub", 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
